spike_aer_encoder: RTL

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

---
 rtl/spike_aer_encoder.sv | 79 +++++++
 1 files changed

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: latches neuron spikes, round-robin arbitrates them into a FIFO
// and emits them as AER addresses with valid/ready handshake and a saturating drop counter.
module spike_aer_encoder #(
  parameter int NUM_NEURONS = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_NEURONS-1:0]         spike_i,
  output logic                           aer_valid_o,
  input  logic                           aer_ready_i,
  output logic [$clog2(NUM_NEURONS)-1:0] aer_addr_o,
  output logic [7:0]                     drop_count_o
);
  localparam int ADDR_W = $clog2(NUM_NEURONS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   N_L  = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [PTR_W:0]    FULL = (PTR_W+1)'(FIFO_DEPTH);

  logic [NUM_NEURONS-1:0] r_pending;
  logic [ADDR_W-1:0]      r_rr_ptr;
  logic [ADDR_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wp, r_rp;
  logic [PTR_W:0]         r_cnt;
  logic [7:0]             r_drop;

  logic [NUM_NEURONS-1:0] w_rot, w_gnt_oh, w_drop;
  logic [ADDR_W-1:0]      w_off, w_gnt, w_nxt;
  logic [ADDR_W:0]        w_sum;
  logic [8:0]             w_ndrop;
  logic [9:0]             w_dsum;
  logic                   w_pop, w_grant;

  assign aer_valid_o  = r_cnt != '0;
  assign aer_addr_o   = aer_valid_o ? r_mem[r_rp] : '0;
  assign drop_count_o = r_drop;
  assign w_pop        = aer_valid_o && aer_ready_i;
  assign w_grant      = (|r_pending) && ((r_cnt != FULL) || w_pop);

  // Rotate pending so bit 0 is rr_ptr; the lowest set bit is the winner's offset.
  always_comb begin
    w_rot = NUM_NEURONS'({r_pending, r_pending} >> r_rr_ptr);
    w_off = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) if (w_rot[i]) w_off = ADDR_W'(i);
    w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_gnt    = (w_sum >= N_L) ? ADDR_W'(w_sum - N_L) : w_sum[ADDR_W-1:0];
    w_nxt    = (w_gnt == LAST) ? '0 : w_gnt + 1'b1;
    w_gnt_oh = w_grant ? ({{(NUM_NEURONS-1){1'b0}}, 1'b1} << w_gnt) : '0;
    w_drop   = spike_i & r_pending & ~w_gnt_oh;
    w_ndrop  = '0;
    for (int i = 0; i < NUM_NEURONS; i++) w_ndrop = w_ndrop + {8'b0, w_drop[i]};
    w_dsum   = {2'b0, r_drop} + {1'b0, w_ndrop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_drop    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_gnt_oh) | spike_i;
      if (w_grant) begin
        r_wp     <= r_wp + 1'b1;
        r_rr_ptr <= w_nxt;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt  <= r_cnt + (PTR_W+1)'(w_grant) - (PTR_W+1)'(w_pop);
      r_drop <= (w_dsum > 10'd255) ? 8'hFF : w_dsum[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_grant) r_mem[r_wp] <= w_gnt;
  end
endmodule
